// File: rtl/coord_fifo.sv
// First-word fall-through FIFO of signed (X,Y) coordinate pairs with valid/ready on both sides.
// Optional sticky overflow/underflow flags are built when COORD_FIFO_ERR_FLAGS_EN is defined.
module coord_fifo #(
  parameter int COORD_W = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST_SYNC,
  input  logic               FLUSH,
  input  logic               WR_VALID,
  output logic               WR_READY,
  input  logic [COORD_W-1:0] WR_X,
  input  logic [COORD_W-1:0] WR_Y,
  output logic               RD_VALID,
  input  logic               RD_READY,
  output logic [COORD_W-1:0] RD_X,
  output logic [COORD_W-1:0] RD_Y,
  output logic [ADDR_W:0]    LEVEL
`ifdef COORD_FIFO_ERR_FLAGS_EN
  ,
  output logic               ERR_OVF,
  output logic               ERR_UDF
`endif
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][2*COORD_W-1:0] mem_q, mem_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [2*COORD_W-1:0] head;
  logic wr_en, rd_en, clr;

  assign clr      = RST_SYNC | FLUSH;
  assign WR_READY = (level_q != FULL_LVL);
  assign RD_VALID = (level_q != '0);
  assign wr_en    = WR_VALID & WR_READY;
  assign rd_en    = RD_VALID & RD_READY;
  assign LEVEL    = level_q;

  // Output is forced to zero while empty so stale storage never leaks out.
  assign head = mem_q[rd_ptr_q];
  assign RD_X = RD_VALID ? head[2*COORD_W-1:COORD_W] : '0;
  assign RD_Y = RD_VALID ? head[COORD_W-1:0] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = {WR_X, WR_Y};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) mem_q <= mem_d;

`ifdef COORD_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (WR_VALID & ~WR_READY);
    udf_d = udf_q | (RD_READY & ~RD_VALID);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ERR_OVF = ovf_q;
  assign ERR_UDF = udf_q;
`endif
endmodule

// File: tb/tb_coord_fifo.sv
// Directed bench for coord_fifo (COORD_W=8, DEPTH=4): vector table plus wrap, full-boundary,
// flush/reset and (when COORD_FIFO_ERR_FLAGS_EN is defined) error-flag sequences.
module tb_coord_fifo;
  logic       CLK = 1'b0;
  logic       RST_SYNC = 1'b0, FLUSH = 1'b0, WR_VALID = 1'b0, RD_READY = 1'b0;
  logic [7:0] WR_X = '0, WR_Y = '0;
  logic       WR_READY, RD_VALID;
  logic [7:0] RD_X, RD_Y;
  logic [2:0] LEVEL;
`ifdef COORD_FIFO_ERR_FLAGS_EN
  logic       ERR_OVF, ERR_UDF;
`endif

  int checks = 0;
  int errors = 0;

  coord_fifo #(.COORD_W(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST_SYNC(RST_SYNC), .FLUSH(FLUSH),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_X(WR_X), .WR_Y(WR_Y),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_X(RD_X), .RD_Y(RD_Y),
    .LEVEL(LEVEL)
`ifdef COORD_FIFO_ERR_FLAGS_EN
    , .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, fl, wv, rr;
    logic [7:0] x, y;
    int         lvl;
    logic       rv, wr;
    logic [7:0] ex, ey;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic rst, input logic fl, input logic wv, input logic [7:0] x,
                     input logic [7:0] y, input logic rr);
    RST_SYNC = rst; FLUSH = fl; WR_VALID = wv; WR_X = x; WR_Y = y; RD_READY = rr;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_state(input string tag, input int lvl, input logic rv, input logic wr,
                              input logic [7:0] ex, input logic [7:0] ey);
    chk({tag, ".level"},    int'(LEVEL),    lvl);
    chk({tag, ".rd_valid"}, int'(RD_VALID), int'(rv));
    chk({tag, ".wr_ready"}, int'(WR_READY), int'(wr));
    chk({tag, ".rd_x"},     int'(RD_X),     int'(ex));
    chk({tag, ".rd_y"},     int'(RD_Y),     int'(ey));
  endtask

  vec_t vt[13];

  initial begin
    //          rst   fl    wv    rr    x      y      lvl rv    wr    ex     ey
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  0, 1'b0, 1'b1, 8'd0,  8'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  0, 1'b0, 1'b1, 8'd0,  8'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  8'hFF, 1, 1'b1, 1'b1, 8'd1,  8'hFF};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  8'hFE, 2, 1'b1, 1'b1, 8'd1,  8'hFF};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3,  8'hFD, 3, 1'b1, 1'b1, 8'd1,  8'hFF};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd4,  8'hFC, 4, 1'b1, 1'b0, 8'd1,  8'hFF};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  8'hFB, 4, 1'b1, 1'b0, 8'd1,  8'hFF};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  3, 1'b1, 1'b1, 8'd2,  8'hFE};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  2, 1'b1, 1'b1, 8'd3,  8'hFD};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  1, 1'b1, 1'b1, 8'd4,  8'hFC};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  0, 1'b0, 1'b1, 8'd0,  8'd0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd7,  8'd7,  1, 1'b1, 1'b1, 8'd7,  8'd7};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  0, 1'b0, 1'b1, 8'd0,  8'd0};

    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].rst, vt[i].fl, vt[i].wv, vt[i].x, vt[i].y, vt[i].rr);
      expect_state($sformatf("vec%0d", i), vt[i].lvl, vt[i].rv, vt[i].wr, vt[i].ex, vt[i].ey);
    end

    // Streaming: each edge pushes pair i and pops pair i-1, so the head is always the newest.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'(128 + i), 8'(i * 3), 1'b1);
      expect_state($sformatf("wrap%0d", i), 1, 1'b1, 1'b1, 8'(128 + i), 8'(i * 3));
    end
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    expect_state("wrap_end", 0, 1'b0, 1'b1, 8'd0, 8'd0);

    // Full boundary: pop while full refuses the concurrent write; the held write lands next edge.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'(10 + i), 8'(20 + i), 1'b0);
    expect_state("full", 4, 1'b1, 1'b0, 8'd10, 8'd20);
    cyc(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b1);
    expect_state("full_pop", 3, 1'b1, 1'b1, 8'd11, 8'd21);
    cyc(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
    expect_state("full_held", 4, 1'b1, 1'b0, 8'd11, 8'd21);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    expect_state("drain0", 3, 1'b1, 1'b1, 8'd12, 8'd22);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    expect_state("drain1", 2, 1'b1, 1'b1, 8'd13, 8'd23);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    expect_state("drain2", 1, 1'b1, 1'b1, 8'd9, 8'd9);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    expect_state("drain3", 0, 1'b0, 1'b1, 8'd0, 8'd0);

    // Flush then reset with a concurrent write; both must drop the write and empty the FIFO.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(40 + i), 8'(50 + i), 1'b0);
    expect_state("pre_flush", 3, 1'b1, 1'b1, 8'd40, 8'd50);
    cyc(1'b0, 1'b1, 1'b1, 8'd66, 8'd66, 1'b1);
    expect_state("flush", 0, 1'b0, 1'b1, 8'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h55, 8'hAA, 1'b0);
    expect_state("post_flush", 1, 1'b1, 1'b1, 8'h55, 8'hAA);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 8'(60 + i), 8'(70 + i), 1'b0);
    expect_state("pre_rst", 3, 1'b1, 1'b1, 8'h55, 8'hAA);
    cyc(1'b1, 1'b0, 1'b1, 8'd77, 8'd77, 1'b1);
    expect_state("rst", 0, 1'b0, 1'b1, 8'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h81, 8'h7F, 1'b0);
    expect_state("post_rst", 1, 1'b1, 1'b1, 8'h81, 8'h7F);

`ifdef COORD_FIFO_ERR_FLAGS_EN
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("err_rst.ovf", int'(ERR_OVF), 0);
    chk("err_rst.udf", int'(ERR_UDF), 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 8'(i), 1'b0);
    chk("err_full.ovf", int'(ERR_OVF), 0);
    cyc(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0);
    chk("err_ovf.ovf", int'(ERR_OVF), 1);
    chk("err_ovf.level", int'(LEVEL), 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    chk("err_drain.ovf", int'(ERR_OVF), 1);
    chk("err_drain.udf", int'(ERR_UDF), 0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    chk("err_udf.udf", int'(ERR_UDF), 1);
    chk("err_udf.level", int'(LEVEL), 0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("err_flush.ovf", int'(ERR_OVF), 0);
    chk("err_flush.udf", int'(ERR_UDF), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
